// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and execute-side update bundle for the branch target buffer.
// master is the pipeline, slave is the buffer.
interface branch_target_buffer_if #(
   parameter int WORD_W = 32,
   parameter int PERF_W = 32
);
   logic [WORD_W-1:0] lookup_pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [WORD_W-1:0] pred_npc;
   logic              update_en;
   logic [WORD_W-1:0] update_pc;
   logic              update_taken;
   logic              update_jump;
   logic [WORD_W-1:0] update_target;
   logic              update_mispredict;
   logic              flush_all;
   logic [PERF_W-1:0] perf_mispredict;

   modport master (
      output lookup_pc,
      output update_en,
      output update_pc,
      output update_taken,
      output update_jump,
      output update_target,
      output update_mispredict,
      output flush_all,
      input  pred_hit,
      input  pred_taken,
      input  pred_npc,
      input  perf_mispredict
   );

   modport slave (
      input  lookup_pc,
      input  update_en,
      input  update_pc,
      input  update_taken,
      input  update_jump,
      input  update_target,
      input  update_mispredict,
      input  flush_all,
      output pred_hit,
      output pred_taken,
      output pred_npc,
      output perf_mispredict
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Zero-latency lookup for IF, registered resolution update from EX.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int WORD_W  = 32,
   parameter int CNT_W   = 2,
   parameter int PERF_W  = 32
) (
   input logic                  CLK,
   input logic                  nRST,
   branch_target_buffer_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = WORD_W - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   logic  valid  [ENTRIES];
   tag_t  tags   [ENTRIES];
   word_t target [ENTRIES];
   cnt_t  cnt    [ENTRIES];

   logic [PERF_W-1:0] perf;

   idx_t l_idx;
   tag_t l_tag;
   idx_t u_idx;
   tag_t u_tag;

   logic u_hit;
   logic u_take;
   cnt_t u_cnt;

   logic unused_low;

   assign l_idx = bus.lookup_pc[IDX_W+1:2];
   assign l_tag = bus.lookup_pc[WORD_W-1:IDX_W+2];
   assign u_idx = bus.update_pc[IDX_W+1:2];
   assign u_tag = bus.update_pc[WORD_W-1:IDX_W+2];

   assign unused_low = ^bus.update_pc[1:0];

   // Lookup sees pre-update contents; no bypass from the EX write.
   always_comb begin
      bus.pred_hit   = valid[l_idx] && (tags[l_idx] == l_tag);
      bus.pred_taken = bus.pred_hit && cnt[l_idx][CNT_W-1];
      bus.pred_npc   = bus.pred_taken ? target[l_idx]
                                      : bus.lookup_pc + WORD_W'(4);
   end

   assign bus.perf_mispredict = perf;

   always_comb begin
      u_hit  = valid[u_idx] && (tags[u_idx] == u_tag);
      u_take = bus.update_taken || bus.update_jump;
      u_cnt  = cnt[u_idx];
      if (bus.update_jump) begin
         u_cnt = CNT_MAX;
      end else if (bus.update_taken) begin
         if (cnt[u_idx] != CNT_MAX) u_cnt = cnt[u_idx] + 1'b1;
      end else begin
         if (cnt[u_idx] != '0) u_cnt = cnt[u_idx] - 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tags[i]   <= '0;
            target[i] <= '0;
            cnt[i]    <= '0;
         end
      end else if (bus.flush_all) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i] <= 1'b0;
            cnt[i]   <= '0;
         end
      end else if (bus.update_en) begin
         if (u_hit) begin
            cnt[u_idx] <= u_cnt;
            if (u_take) target[u_idx] <= bus.update_target;
         end else if (u_take) begin
            valid[u_idx]  <= 1'b1;
            tags[u_idx]   <= u_tag;
            target[u_idx] <= bus.update_target;
            cnt[u_idx]    <= bus.update_jump ? CNT_MAX : CNT_WEAK;
         end
      end
   end

   // A flushed update is dropped entirely, so it is not counted either.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf <= '0;
      end else if (bus.update_en && bus.update_mispredict
                   && !bus.flush_all) begin
         perf <= perf + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed vectors queue
// expected lookup results, a negedge monitor pops and compares.
module tb_branch_target_buffer;
   logic CLK;
   logic nRST;

   branch_target_buffer_if #(.WORD_W(32), .PERF_W(32)) bus ();

   branch_target_buffer #(
      .ENTRIES(16),
      .WORD_W (32),
      .CNT_W  (2),
      .PERF_W (32)
   ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic        hit;
      logic        taken;
      logic [31:0] npc;
      logic [31:0] perf;
   } exp_t;

   exp_t exp_q[$];
   int   errors;
   int   checks;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (bus.pred_hit !== e.hit) begin
            errors++;
            $display("FAIL %s hit: got %0b want %0b",
                     e.name, bus.pred_hit, e.hit);
         end
         checks++;
         if (bus.pred_taken !== e.taken) begin
            errors++;
            $display("FAIL %s taken: got %0b want %0b",
                     e.name, bus.pred_taken, e.taken);
         end
         checks++;
         if (bus.pred_npc !== e.npc) begin
            errors++;
            $display("FAIL %s npc: got %h want %h",
                     e.name, bus.pred_npc, e.npc);
         end
         checks++;
         if (bus.perf_mispredict !== e.perf) begin
            errors++;
            $display("FAIL %s perf: got %0d want %0d",
                     e.name, bus.perf_mispredict, e.perf);
         end
      end
   end

   task automatic push(input string n, input logic h, input logic t,
                       input logic [31:0] npc, input logic [31:0] p);
      exp_t e;
      e.name  = n;
      e.hit   = h;
      e.taken = t;
      e.npc   = npc;
      e.perf  = p;
      exp_q.push_back(e);
   endtask

   task automatic clear_upd();
      bus.update_en         = 1'b0;
      bus.update_pc         = '0;
      bus.update_taken      = 1'b0;
      bus.update_jump       = 1'b0;
      bus.update_target     = '0;
      bus.update_mispredict = 1'b0;
      bus.flush_all         = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      clear_upd();
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic tk,
                          input logic jp, input logic [31:0] tg,
                          input logic mis);
      bus.update_en         = 1'b1;
      bus.update_pc         = pc;
      bus.update_taken      = tk;
      bus.update_jump       = jp;
      bus.update_target     = tg;
      bus.update_mispredict = mis;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk,
                      input logic jp, input logic [31:0] tg,
                      input logic mis);
      set_upd(pc, tk, jp, tg, mis);
      tick();
   endtask

   task automatic look(input string n, input logic [31:0] pc,
                       input logic h, input logic t,
                       input logic [31:0] npc, input logic [31:0] p);
      bus.lookup_pc = pc;
      push(n, h, t, npc, p);
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      nRST = 1'b0;
      bus.lookup_pc = '0;
      clear_upd();
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;

      look("reset", 32'h40, 0, 0, 32'h44, 0);

      upd(32'h40, 1, 0, 32'h100, 1);
      look("alloc", 32'h40, 1, 1, 32'h100, 1);

      upd(32'h40, 0, 0, 32'h0, 1);
      look("weak_nt", 32'h40, 1, 0, 32'h44, 2);
      upd(32'h40, 0, 0, 32'h0, 0);
      upd(32'h40, 0, 0, 32'h0, 0);
      look("sat_zero", 32'h40, 1, 0, 32'h44, 2);
      upd(32'h40, 1, 0, 32'h100, 0);
      look("cnt_one", 32'h40, 1, 0, 32'h44, 2);

      upd(32'h80, 1, 0, 32'h200, 0);
      look("alias_old", 32'h40, 0, 0, 32'h44, 2);
      look("alias_new", 32'h80, 1, 1, 32'h200, 2);
      upd(32'h1040, 0, 0, 32'h0, 0);
      look("nt_miss_keep", 32'h80, 1, 1, 32'h200, 2);
      look("nt_miss_none", 32'h1040, 0, 0, 32'h1044, 2);

      upd(32'h7C, 0, 1, 32'h300, 0);
      look("jump", 32'h7C, 1, 1, 32'h300, 2);
      upd(32'h7C, 1, 0, 32'h300, 0);
      upd(32'h7C, 0, 0, 32'h0, 0);
      look("sat_max", 32'h7C, 1, 1, 32'h300, 2);
      upd(32'h7C, 0, 0, 32'h0, 0);
      look("drop_weak", 32'h7C, 1, 0, 32'h80, 2);
      look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0, 2);

      // same-cycle lookup must see the pre-update table
      set_upd(32'h140, 1, 0, 32'h500, 0);
      bus.lookup_pc = 32'h140;
      push("no_bypass", 0, 0, 32'h144, 2);
      tick();
      look("after_bypass", 32'h140, 1, 1, 32'h500, 2);

      bus.update_mispredict = 1'b1;
      tick();
      look("mis_no_en", 32'h140, 1, 1, 32'h500, 2);

      set_upd(32'h40, 1, 0, 32'h100, 1);
      bus.flush_all = 1'b1;
      tick();
      look("flush_40", 32'h40, 0, 0, 32'h44, 2);
      look("flush_7c", 32'h7C, 0, 0, 32'h80, 2);
      look("flush_140", 32'h140, 0, 0, 32'h144, 2);

      upd(32'h40, 1, 0, 32'h100, 1);
      look("post_flush", 32'h40, 1, 1, 32'h100, 3);

      nRST = 1'b0;
      bus.lookup_pc = 32'h40;
      push("async_rst", 0, 0, 32'h44, 0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      upd(32'h40, 0, 0, 32'h0, 1);
      look("rst_nt_miss", 32'h40, 0, 0, 32'h44, 1);

      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with saturating-counter direction prediction for the pipelined MIPS datapath.
- The IF stage looks up the current PC combinationally and receives a predicted next PC.
- The EX stage writes back resolved branch and jump outcomes.
- Replaces the fixed "predict not-taken, flush on every taken branch" policy with a configurable depth and counter width, plus a mispredict performance counter.

Parameters:
- ENTRIES, 16, number of entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- WORD_W, 32, PC and target width.
- CNT_W, 2, saturating counter width, at least 1.
- PERF_W, 32, width of the mispredict counter.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- lookup_pc  in  WORD_W  PC being fetched (IF).
- pred_hit  out  1  valid entry whose tag matches lookup_pc.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_npc  out  WORD_W  stored target if pred_taken, else lookup_pc+4.
- update_en  in  1  resolved control-transfer instruction in EX, already stall-qualified.
- update_pc  in  WORD_W  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_jump  in  1  unconditional J/JAL; implies taken.
- update_target  in  WORD_W  actual target.
- update_mispredict  in  1  EX detected a wrong prediction (direction or target).
- flush_all  in  1  synchronous invalidate of all entries.
- perf_mispredict  out  PERF_W  count of mispredicts.

Behaviour:
- Fixed facts: one clock, CLK; reset nRST is asynchronous, active-low.
- Address fields:
  - index = pc[IDX_W+1:2]
  - tag = pc[WORD_W-1:IDX_W+2]
  - pc[1:0] ignored.
- Entry contents: valid, tag, target, counter.
- Counter states for CNT_W=2: 0 = strongly not-taken, 1 = weakly not-taken, 2 = weakly taken, 3 = strongly taken. Predict taken when the MSB is 1.
- Reset: all valid bits 0, counters 0, targets 0, perf_mispredict 0.
  - While no entry is valid, outputs are pred_hit=0, pred_taken=0, pred_npc=lookup_pc+4.
- Lookup: purely combinational, zero latency. pred_npc addition wraps modulo 2^WORD_W.
- Update is registered and takes effect at the next rising edge.
  - Hit (valid and tag match): if update_jump, counter becomes max (2^CNT_W-1). Else saturating increment if taken, saturating decrement if not; no wrap at 0 or max. If taken, the target is overwritten with update_target. If not taken, the target is unchanged.
  - Miss, taken (or jump): allocate, overwriting the resident entry. Set valid=1, tag, target. Counter = max if jump, else 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no allocation; state unchanged.
- Simultaneous lookup and update to the same index in the same cycle: lookup returns the pre-update contents. There is no bypass.
- perf_mispredict increments by 1 on each edge where update_en and update_mispredict are both 1. It wraps at 2^PERF_W. It is not cleared by flush_all. update_mispredict without update_en is ignored.
- flush_all: at the next edge all valid bits are 0 and counters are 0. flush_all has priority over a concurrent update (the update is dropped).
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. The first update after release behaves as on an empty table.
- CNT_W=1: the counter toggles between 0 and 1. Allocation sets it to 1.

Test Plan (ENTRIES=16, CNT_W=2):
- Reset, then lookup_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_npc=0x00000044; perf_mispredict=0.
- Update pc=0x40, taken=1, target=0x100, mispredict=1; next cycle lookup 0x40 -> hit=1, taken=1, npc=0x100, perf=1.
- Two not-taken updates to 0x40 (counter 2->1->0), then a third -> counter stays 0; lookup -> hit=1, taken=0, npc=0x44. One taken update -> counter 1, still not taken.
- Alias: entry at 0x40 valid, then taken update pc=0x80 (same index 0, different tag), target 0x200 -> lookup 0x40 hit=0; lookup 0x80 npc=0x200. Not-taken update at 0x1040 does not evict 0x80.
- Jump update pc=0x7C, jump=1, target=0x300 -> counter 3; one not-taken update -> counter 2, still predicts 0x300. Lookup of 0xFFFFFFFC on a miss -> npc=0x00000000 (wrap).
- flush_all concurrent with update to 0x40 -> all lookups miss afterward, perf unchanged. Assert nRST mid-cycle -> perf=0 immediately.
